// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_e;

  localparam int unsigned OCC_W = 2;

  // Replicated across the control field to form a bubble.
  localparam bit CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_entry.sv
// One {valid, data, ctrl} storage entry with clear (flush), load and drop controls.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned CTRL_W         = 8,
  parameter bit          FLUSH_CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Priority: clear over load over drop; drop keeps payload to avoid toggling.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_W{CTRL_BUBBLE}};
      if (FLUSH_CLR_DATA) begin
        data <= '0;
      end
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
      ctrl  <= ld_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned CTRL_W         = 8,
  parameter bit          FLUSH_CLR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  skid_state_e state_q, state_d;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
  logic              main_load, main_drop, main_from_skid;
  logic              skid_load, skid_drop;
  logic              acc, pop;

  // in_ready comes straight from a flop: no path from out_ready.
  assign in_ready  = ~skid_valid;
  assign acc       = in_valid & in_ready & ~flush;
  assign pop       = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : {CTRL_W{CTRL_BUBBLE}};
  assign occupancy = OCC_W'(main_valid) + OCC_W'(skid_valid);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (pop) begin
            main_drop = 1'b1;
            state_d   = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_ld_data = main_from_skid ? skid_data : in_data;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_entry #(
    .DATA_W         (DATA_W),
    .CTRL_W         (CTRL_W),
    .FLUSH_CLR_DATA (FLUSH_CLR_DATA)
  ) u_main (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (flush),
    .load    (main_load),
    .drop    (main_drop),
    .ld_data (main_ld_data),
    .ld_ctrl (main_ld_ctrl),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_entry #(
    .DATA_W         (DATA_W),
    .CTRL_W         (CTRL_W),
    .FLUSH_CLR_DATA (FLUSH_CLR_DATA)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (flush),
    .load    (skid_load),
    .drop    (skid_drop),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised bench for pipe_skid_reg against a queue-based model; two DUTs cover both flush-data modes.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [1:0]    occ1, occ0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CLR_DATA(1'b1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_ctrl  (out_ctrl1),
    .occupancy (occ1)
  );

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CLR_DATA(1'b0)) dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .out_ctrl  (out_ctrl0),
    .occupancy (occ0)
  );

  always @(negedge clk) begin
    if (rstn) begin
      assert (!dut.skid_valid || dut.main_valid) else $error("skid_valid without main_valid");
      assert (occ1 != 2'd3) else $error("occupancy reached 3");
      assert (!(dut.acc && !in_ready1)) else $error("acc while in_ready low");
      assert (!dut0.skid_valid || dut0.main_valid) else $error("dut0 skid without main");
      assert (occ0 != 2'd3) else $error("dut0 occupancy reached 3");
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] m_data1, m_data0;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_deliv = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic          ev;
    logic [CW-1:0] ec;
    ev = (q.size() > 0);
    ec = ev ? q[0].c : '0;
    check_eq("out_valid", 64'(out_valid1), 64'(ev));
    check_eq("in_ready", 64'(in_ready1), 64'(q.size() < 2));
    check_eq("occupancy", 64'(occ1), 64'(q.size()));
    check_eq("out_ctrl", 64'(out_ctrl1), 64'(ec));
    check_eq("out_data", 64'(out_data1), 64'(m_data1));
    check_eq("out_valid0", 64'(out_valid0), 64'(ev));
    check_eq("in_ready0", 64'(in_ready0), 64'(q.size() < 2));
    check_eq("occupancy0", 64'(occ0), 64'(q.size()));
    check_eq("out_ctrl0", 64'(out_ctrl0), 64'(ec));
    check_eq("out_data0", 64'(out_data0), 64'(m_data0));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    logic  acc, pop;
    beat_t b;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc = iv && (q.size() < 2) && !fl;
    pop = (q.size() > 0) && ordy;
    if (pop) n_deliv++;
    if (fl) begin
      q.delete();
      m_data1 = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        b.d = d;
        b.c = c;
        q.push_back(b);
      end
    end
    if (q.size() > 0) begin
      m_data1 = q[0].d;
      m_data0 = q[0].d;
    end
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    m_data1 = '0;
    m_data0 = '0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // Fill to two entries, then reset asynchronously mid-cycle.
    cycle(1'b1, 16'h0BAD, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 16'h0BEE, 8'hEF, 1'b0, 1'b0);
    check_eq("pre_reset_occ", 64'(occ1), 64'd2);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b1, 16'h00A5, 8'h1F, 1'b0, 1'b0);
    check_eq("first_beat", 64'(out_data1), 64'h00A5);

    // Drain, then stream 0x01..0x10 at full rate.
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall into the skid; 0x33 waits for in_ready to return.
    cycle(1'b1, 16'h0011, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 16'h0022, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 16'h0033, 8'h03, 1'b0, 1'b0);
    check_eq("stall_hold", 64'(out_data1), 64'h0011);
    cycle(1'b1, 16'h0033, 8'h03, 1'b1, 1'b0);
    check_eq("skid_out", 64'(out_data1), 64'h0022);
    cycle(1'b1, 16'h0033, 8'h03, 1'b1, 1'b0);
    check_eq("late_accept", 64'(out_data1), 64'h0033);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush a full stage with a beat on the input.
    cycle(1'b1, 16'h0055, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 16'h0066, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 16'h0044, 8'hFF, 1'b0, 1'b1);
    check_eq("flush_data_clr", 64'(out_data1), 64'h0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush coinciding with a pop.
    cycle(1'b1, 16'h0077, 8'h03, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    check_eq("flush_stale", 64'(out_data0), 64'h0077);

    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
